// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin arbiter: shares one AXI-Stream output among CHANNEL_NUMBER
// input queues, holding each grant from first beat through TLAST and counting packets.
module axis_packet_rr_arbiter #(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int DATA_WIDTH           = 32,
  parameter int PKT_CNT_WIDTH        = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [CHANNEL_NUMBER-1:0]            in_tvalid_i,
  input  logic [CHANNEL_NUMBER-1:0]            in_tlast_i,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_tdata_i,
  output logic [CHANNEL_NUMBER-1:0]            in_tready_o,
  output logic                                 out_tvalid_o,
  output logic                                 out_tlast_o,
  output logic [DATA_WIDTH-1:0]                out_tdata_o,
  input  logic                                 out_tready_i,
  output logic [CHANNEL_NUMBER-1:0]            grant_o,
  output logic [CHANNEL_NUMBER_WIDTH-1:0]      grant_idx_o,
  output logic                                 busy_o,
  output logic [PKT_CNT_WIDTH-1:0]             pkt_cnt_o
);
  // state | meaning
  // IDLE  | no grant; arbitrate among requesting channels starting at rr_ptr
  // BUSY  | granted channel forwarded combinationally until its TLAST beat handshakes
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam int W = CHANNEL_NUMBER_WIDTH;

  state_t                   state_q, state_d;
  logic [W-1:0]             grant_idx_q, grant_idx_d;
  logic [W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

  logic         sel_found;
  logic [W-1:0] sel_idx;
  logic [W-1:0] sel_next;
  logic         last_hs;
  int           cand;

  // First requesting channel at or after rr_ptr, wrapping at CHANNEL_NUMBER-1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int off = 0; off < CHANNEL_NUMBER; off++) begin
      cand = (int'(rr_ptr_q) + off) % CHANNEL_NUMBER;
      if (!sel_found && in_tvalid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = W'(cand);
      end
    end
  end

  assign sel_next = (sel_idx == W'(CHANNEL_NUMBER - 1)) ? '0 : sel_idx + W'(1);
  assign last_hs  = (state_q == S_BUSY) && in_tvalid_i[grant_idx_q] && in_tlast_i[grant_idx_q]
                    && out_tready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_cnt_d   = pkt_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d     = S_BUSY;
          grant_idx_d = sel_idx;
          rr_ptr_d    = sel_next;
        end
      end
      S_BUSY: begin
        // The idle bubble after every packet is the re-arbitration cycle.
        if (last_hs) begin
          state_d     = S_IDLE;
          grant_idx_d = '0;
          if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + PKT_CNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_tready_o  = '0;
    out_tvalid_o = 1'b0;
    out_tlast_o  = 1'b0;
    out_tdata_o  = '0;
    grant_o      = '0;
    busy_o       = 1'b0;
    if (state_q == S_BUSY) begin
      busy_o                   = 1'b1;
      grant_o[grant_idx_q]     = 1'b1;
      in_tready_o[grant_idx_q] = out_tready_i;
      out_tvalid_o             = in_tvalid_i[grant_idx_q];
      out_tlast_o              = in_tlast_i[grant_idx_q];
      out_tdata_o              = in_tdata_i[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant_idx_o = grant_idx_q;
  assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Self-checking bench for axis_packet_rr_arbiter: directed scenarios plus randomized traffic
// compared against a packet-level round-robin reference model.
module tb_axis_packet_rr_arbiter;
  localparam int N  = 5;
  localparam int W  = 3;
  localparam int DW = 32;
  localparam int CW = 16;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    in_tvalid_i, in_tlast_i, in_tready_o;
  logic [N*DW-1:0] in_tdata_i;
  logic            out_tvalid_o, out_tlast_o, out_tready_i, busy_o;
  logic [DW-1:0]   out_tdata_o;
  logic [N-1:0]    grant_o;
  logic [W-1:0]    grant_idx_o;
  logic [CW-1:0]   pkt_cnt_o;

  axis_packet_rr_arbiter #(.CHANNEL_NUMBER(N), .CHANNEL_NUMBER_WIDTH(W), .DATA_WIDTH(DW),
                           .PKT_CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_tvalid_i(in_tvalid_i), .in_tlast_i(in_tlast_i),
    .in_tdata_i(in_tdata_i), .in_tready_o(in_tready_o), .out_tvalid_o(out_tvalid_o),
    .out_tlast_o(out_tlast_o), .out_tdata_o(out_tdata_o), .out_tready_i(out_tready_i),
    .grant_o(grant_o), .grant_idx_o(grant_idx_o), .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o));

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: owning channel (-1 = no packet in flight), next priority, packet count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  task automatic tick();
    if (rst_i) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (in_tvalid_i[c]) begin
          m_owner = c; m_ptr = (c + 1) % N;
          break;
        end
      end
    end else if (in_tvalid_i[m_owner] && out_tready_i && in_tlast_i[m_owner]) begin
      m_owner = -1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ch(input int c, input logic v, input logic l, input logic [DW-1:0] d);
    in_tvalid_i[c] = v;
    in_tlast_i[c]  = l;
    in_tdata_i[c*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; in_tvalid_i = '1; out_tready_i = 1'b1;
    tick(); tick(); #1;
    checks++; if (grant_o !== 5'b0) begin errors++; $display("FAIL reset_grant: got %b exp 00000", grant_o); end
    checks++; if (out_tvalid_o !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b exp 0", out_tvalid_o); end
    checks++; if (pkt_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", pkt_cnt_o); end
    checks++; if (in_tready_o !== 5'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_ready_busy: got %b/%b exp 00000/0", in_tready_o, busy_o); end
    rst_i = 1'b0; in_tvalid_i = '0;
    tick();
  endtask

  task automatic test_single();
    set_ch(2, 1'b1, 1'b0, 32'hA); #1;
    checks++; if (grant_o !== 5'b0) begin errors++; $display("FAIL single_pre_grant: got %b exp 00000", grant_o); end
    tick(); #1;
    checks++; if (grant_o !== 5'b00100 || grant_idx_o !== 3'd2) begin errors++; $display("FAIL single_grant: got %b/%0d exp 00100/2", grant_o, grant_idx_o); end
    checks++; if (out_tvalid_o !== 1'b1 || out_tdata_o !== 32'hA || in_tready_o !== 5'b00100) begin errors++; $display("FAIL single_beat0: got v=%b d=%h r=%b exp 1/a/00100", out_tvalid_o, out_tdata_o, in_tready_o); end
    tick(); set_ch(2, 1'b1, 1'b0, 32'hB); #1;
    checks++; if (out_tdata_o !== 32'hB || out_tlast_o !== 1'b0) begin errors++; $display("FAIL single_beat1: got %h/%b exp b/0", out_tdata_o, out_tlast_o); end
    tick(); set_ch(2, 1'b1, 1'b1, 32'hC); #1;
    checks++; if (out_tdata_o !== 32'hC || out_tlast_o !== 1'b1) begin errors++; $display("FAIL single_beat2: got %h/%b exp c/1", out_tdata_o, out_tlast_o); end
    tick(); set_ch(2, 1'b0, 1'b0, 32'h0); #1;
    checks++; if (pkt_cnt_o !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d exp 1", pkt_cnt_o); end
    checks++; if (grant_o !== 5'b0 || busy_o !== 1'b0 || out_tdata_o !== 32'h0 || out_tlast_o !== 1'b0) begin errors++; $display("FAIL single_idle: got g=%b b=%b d=%h l=%b", grant_o, busy_o, out_tdata_o, out_tlast_o); end
  endtask

  task automatic test_all_rr();
    logic [N-1:0] eg;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b1, DW'(c));
    out_tready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      eg = '0; eg[i % N] = 1'b1;
      checks++; if (grant_o !== eg || out_tdata_o !== DW'(i % N)) begin errors++; $display("FAIL rr_grant%0d: got %b/%h exp %b/%h", i, grant_o, out_tdata_o, eg, i % N); end
      tick(); #1;
      checks++; if (grant_o !== 5'b0 || out_tvalid_o !== 1'b0) begin errors++; $display("FAIL rr_bubble%0d: got %b/%b exp 00000/0", i, grant_o, out_tvalid_o); end
    end
    checks++; if (pkt_cnt_o !== 16'd6) begin errors++; $display("FAIL rr_cnt: got %0d exp 6", pkt_cnt_o); end
    in_tvalid_i = '0; in_tlast_i = '0;
    tick();
  endtask

  task automatic test_backpressure();
    int b = 0;
    int t = 0;
    set_ch(1, 1'b1, 1'b0, 32'h10);
    set_ch(3, 1'b1, 1'b1, 32'h33);
    out_tready_i = 1'b0;
    tick();
    while (b < 4 && t < 20) begin
      out_tready_i = (t % 2 == 0); #1;
      checks++; if (grant_o !== 5'b00010 || in_tready_o !== {3'b0, out_tready_i, 1'b0}) begin errors++; $display("FAIL bp_ready_t%0d: got g=%b r=%b exp 00010 r[1]=%b", t, grant_o, in_tready_o, out_tready_i); end
      checks++; if (out_tdata_o !== DW'(32'h10 + b) || out_tlast_o !== (b == 3)) begin errors++; $display("FAIL bp_beat_t%0d: got %h/%b exp %h/%b", t, out_tdata_o, out_tlast_o, 32'h10 + b, b == 3); end
      tick();
      if (out_tready_i) b++;
      if (b < 4) set_ch(1, 1'b1, b == 3, DW'(32'h10 + b)); else set_ch(1, 1'b0, 1'b0, 32'h0);
      t++;
    end
    checks++; if (b != 4) begin errors++; $display("FAIL bp_timeout: got %0d beats exp 4", b); end
    #1;
    checks++; if (grant_o !== 5'b0) begin errors++; $display("FAIL bp_bubble: got %b exp 00000", grant_o); end
    out_tready_i = 1'b1;
    tick(); #1;
    checks++; if (grant_o !== 5'b01000 || out_tdata_o !== 32'h33) begin errors++; $display("FAIL bp_ch3: got %b/%h exp 01000/33", grant_o, out_tdata_o); end
    tick(); set_ch(3, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_stall();
    set_ch(0, 1'b1, 1'b0, 32'hA0);
    tick();
    set_ch(4, 1'b1, 1'b1, 32'h44); #1;
    checks++; if (grant_o !== 5'b00001 || out_tdata_o !== 32'hA0) begin errors++; $display("FAIL stall_grant: got %b/%h exp 00001/a0", grant_o, out_tdata_o); end
    tick(); set_ch(0, 1'b0, 1'b0, 32'hA0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (grant_o !== 5'b00001 || out_tvalid_o !== 1'b0 || in_tready_o !== 5'b00001) begin errors++; $display("FAIL stall_hold%0d: got g=%b v=%b r=%b exp 00001/0/00001", i, grant_o, out_tvalid_o, in_tready_o); end
      tick();
    end
    set_ch(0, 1'b1, 1'b1, 32'hA1); #1;
    checks++; if (grant_o !== 5'b00001 || out_tdata_o !== 32'hA1) begin errors++; $display("FAIL stall_last: got %b/%h exp 00001/a1", grant_o, out_tdata_o); end
    tick(); set_ch(0, 1'b0, 1'b0, 32'h0); #1;
    checks++; if (grant_o !== 5'b0) begin errors++; $display("FAIL stall_bubble: got %b exp 00000", grant_o); end
    tick(); #1;
    checks++; if (grant_o !== 5'b10000 || out_tdata_o !== 32'h44) begin errors++; $display("FAIL stall_ch4: got %b/%h exp 10000/44", grant_o, out_tdata_o); end
    tick(); set_ch(4, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    set_ch(3, 1'b1, 1'b0, 32'h30);
    tick(); #1;
    checks++; if (grant_o !== 5'b01000) begin errors++; $display("FAIL rmid_grant: got %b exp 01000", grant_o); end
    tick(); set_ch(3, 1'b1, 1'b0, 32'h31);
    rst_i = 1'b1;
    tick(); #1;
    checks++; if (grant_o !== 5'b0 || busy_o !== 1'b0 || out_tvalid_o !== 1'b0) begin errors++; $display("FAIL rmid_drop: got g=%b b=%b v=%b exp 0/0/0", grant_o, busy_o, out_tvalid_o); end
    rst_i = 1'b0;
    set_ch(0, 1'b1, 1'b1, 32'h0A);
    tick(); #1;
    checks++; if (grant_o !== 5'b00001 || out_tdata_o !== 32'h0A) begin errors++; $display("FAIL rmid_ch0_first: got %b/%h exp 00001/0a", grant_o, out_tdata_o); end
  endtask

  task automatic test_random();
    int beat[N];
    int len[N];
    int seq[N];
    int hs_c;
    logic [N-1:0]  eg, er;
    logic          ev, el;
    logic [DW-1:0] ed;
    rst_i = 1'b1; in_tvalid_i = '0; in_tlast_i = '0; in_tdata_i = '0;
    tick(); rst_i = 1'b0;
    for (int c = 0; c < N; c++) begin beat[c] = 0; seq[c] = 0; len[c] = $urandom_range(1, 4); end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++)
        if (!in_tvalid_i[c] && $urandom_range(3) == 0)
          set_ch(c, 1'b1, beat[c] == len[c] - 1, {8'(c), 8'(seq[c]), 16'(beat[c])});
      out_tready_i = ($urandom_range(3) != 0);
      #1;
      eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0; hs_c = -1;
      if (m_owner >= 0) begin
        eg[m_owner] = 1'b1;
        er[m_owner] = out_tready_i;
        ev = in_tvalid_i[m_owner];
        el = in_tlast_i[m_owner];
        ed = {8'(m_owner), 8'(seq[m_owner]), 16'(beat[m_owner])};
        if (ev && out_tready_i) hs_c = m_owner;
      end
      checks++; if (grant_o !== eg || busy_o !== (m_owner >= 0)) begin errors++; $display("FAIL rnd_grant c%0d: got %b/%b exp %b", cyc, grant_o, busy_o, eg); end
      checks++; if (grant_idx_o !== W'(m_owner < 0 ? 0 : m_owner)) begin errors++; $display("FAIL rnd_idx c%0d: got %0d exp %0d", cyc, grant_idx_o, m_owner); end
      checks++; if (in_tready_o !== er) begin errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", cyc, in_tready_o, er); end
      checks++; if (out_tvalid_o !== ev || out_tlast_o !== (ev & el)) begin errors++; $display("FAIL rnd_vl c%0d: got %b/%b exp %b/%b", cyc, out_tvalid_o, out_tlast_o, ev, ev & el); end
      checks++; if (ev && out_tdata_o !== ed) begin errors++; $display("FAIL rnd_data c%0d: got %h exp %h", cyc, out_tdata_o, ed); end
      checks++; if (pkt_cnt_o !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d exp %0d", cyc, pkt_cnt_o, m_cnt); end
      tick();
      if (hs_c >= 0) begin
        if (in_tlast_i[hs_c]) begin
          beat[hs_c] = 0; seq[hs_c]++; len[hs_c] = $urandom_range(1, 4);
        end else beat[hs_c]++;
        set_ch(hs_c, 1'b0, 1'b0, 32'h0);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; in_tvalid_i = '0; in_tlast_i = '0; in_tdata_i = '0; out_tready_i = 1'b0;
    test_reset();
    test_single();
    test_all_rr();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
